// File: rtl/instr_mem_arb_if.sv
// Fetch-side bundle between the cores and the instruction memory arbiter.
// The core side drives requests; the arbiter side grants and responds.
interface instr_mem_arb_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        fetch_req;
  logic [NUM_PORTS*ADDR_W-1:0] fetch_addr;
  logic [NUM_PORTS-1:0]        fetch_gnt;
  logic [NUM_PORTS-1:0]        fetch_valid;
  logic [NUM_PORTS*DATA_W-1:0] fetch_instr;
  logic [NUM_PORTS-1:0]        fetch_fault;

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_valid, fetch_instr, fetch_fault
  );

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_valid, fetch_instr, fetch_fault
  );
endinterface

// File: rtl/instr_mem_arb.sv
// Round-robin instruction memory arbiter: fetch ports share one read port,
// and a program-load port pre-empts fetches in the cycle it writes.
module instr_mem_arb #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 64,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  instr_mem_arb_if.slave    bus
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WRD_W = ADDR_W - 2;

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic [PTR_W-1:0]            rr_q, rr_d;
  logic [NUM_PORTS-1:0]        valid_q, valid_d;
  logic [NUM_PORTS-1:0]        fault_q, fault_d;
  logic [NUM_PORTS*DATA_W-1:0] instr_q, instr_d;

  logic [NUM_PORTS-1:0] gnt;
  logic [PTR_W-1:0]     gidx;
  logic                 any_gnt;
  logic [ADDR_W-1:0]    gaddr;
  logic [WRD_W-1:0]     gword, lword;
  logic                 gfault, lok;

  // Load and reset both silence the arbiter for the whole cycle.
  always_comb begin
    gnt     = '0;
    gidx    = '0;
    any_gnt = 1'b0;
    if (reset && !load_en) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!any_gnt &&
            bus.fetch_req[(int'(rr_q) + i) % NUM_PORTS]) begin
          any_gnt = 1'b1;
          gidx    = PTR_W'((int'(rr_q) + i) % NUM_PORTS);
        end
      end
    end
    if (any_gnt) gnt[gidx] = 1'b1;
  end

  assign gaddr  = bus.fetch_addr[gidx*ADDR_W +: ADDR_W];
  assign gword  = gaddr[ADDR_W-1:2];
  assign gfault = (gaddr[1:0] != 2'b00) ||
                  (gword >= WRD_W'(DEPTH));

  assign lword = load_addr[ADDR_W-1:2];
  assign lok   = load_en && (load_addr[1:0] == 2'b00) &&
                 (lword < WRD_W'(DEPTH));

  always_comb begin
    rr_d    = rr_q;
    valid_d = gnt;
    fault_d = fault_q;
    instr_d = instr_q;
    if (any_gnt) begin
      rr_d = (int'(gidx) == NUM_PORTS - 1) ? '0 : gidx + 1'b1;
      fault_d[gidx] = gfault;
      instr_d[gidx*DATA_W +: DATA_W] =
        gfault ? '0 : mem_q[gword[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q    <= '0;
      valid_q <= '0;
      fault_q <= '0;
      instr_q <= '0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
    end
  end

  // Contents survive reset; only writes are blocked while it is held.
  always_ff @(posedge clk) begin
    if (reset && lok) mem_q[lword[IDX_W-1:0]] <= load_data;
  end

  assign bus.fetch_gnt   = gnt;
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_instr = instr_q;
endmodule

// File: tb/tb_instr_mem_arb.sv
// Bench for instr_mem_arb: per-cycle reference model check
// plus directed scenarios with hand-derived literal expectations.
module tb_instr_mem_arb;
  localparam int NP    = 2;
  localparam int DEPTH = 64;
  localparam int DW    = 32;
  localparam int AW    = 32;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          load_en   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;

  int checks = 0;
  int errors = 0;

  instr_mem_arb_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_mem_arb #(
    .NUM_PORTS(NP), .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: word array, pointer and last response per port.
  logic [DW-1:0] mem_m [DEPTH] = '{default: '0};
  int            rr_m = 0;
  logic [NP-1:0] ev = '0;
  logic [NP-1:0] ef = '0;
  logic [DW-1:0] ei [NP] = '{default: '0};
  int            g_m;
  int            g_c;
  logic [AW-1:0] a_m;
  logic [NP-1:0] eg;

  function automatic int pick();
    if (reset !== 1'b1 || load_en) return -1;
    for (int k = 0; k < NP; k++)
      if (bus.fetch_req[(rr_m + k) % NP]) return (rr_m + k) % NP;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev   = '0;
      ef   = '0;
      ei   = '{default: '0};
      rr_m = 0;
    end else begin
      g_m = pick();
      ev  = '0;
      if (load_en && load_addr[1:0] == 2'b00 && (load_addr >> 2) < DEPTH)
        mem_m[load_addr[7:2]] = load_data;
      if (g_m >= 0) begin
        a_m      = bus.fetch_addr[g_m*AW +: AW];
        ev[g_m]  = 1'b1;
        ef[g_m]  = (a_m[1:0] != 2'b00) || ((a_m >> 2) >= DEPTH);
        ei[g_m]  = ef[g_m] ? '0 : mem_m[a_m[7:2]];
        rr_m     = (g_m + 1) % NP;
      end
    end
  end

  always @(negedge clk) begin
    g_c = pick();
    eg  = '0;
    if (g_c >= 0) eg[g_c] = 1'b1;
    chk("m_gnt",    bus.fetch_gnt,         eg);
    chk("m_valid",  bus.fetch_valid,       ev);
    chk("m_fault",  bus.fetch_fault,       ef);
    chk("m_instr0", bus.fetch_instr[31:0],  ei[0]);
    chk("m_instr1", bus.fetch_instr[63:32], ei[1]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.fetch_req  = '0;
    bus.fetch_addr = '0;
    #1 reset = 1'b0;
    step();
    look();
    chk("rst_valid", bus.fetch_valid, 2'b00);
    chk("rst_instr", bus.fetch_instr, 64'h0);
    chk("rst_fault", bus.fetch_fault, 2'b00);
    step();
    reset = 1'b1;

    load(32'h0,   32'h20080005);
    load(32'h4,   32'h2009000A);
    load(32'h8,   32'h11111111);
    load(32'h100, 32'hFFFFFFFF);
    load(32'h6,   32'hEEEEEEEE);

    // Single fetch: grant same cycle, word next cycle.
    bus.fetch_req  = 2'b01;
    bus.fetch_addr = {32'h0, 32'h4};
    look();
    chk("p32_gnt", bus.fetch_gnt, 2'b01);
    step();
    bus.fetch_req = 2'b00;
    look();
    chk("p32_valid", bus.fetch_valid, 2'b01);
    chk("p32_instr", bus.fetch_instr[31:0], 32'h2009000A);
    chk("p32_fault", bus.fetch_fault[0], 1'b0);
    step();

    // Grants withheld in the cycle reset asserts; pointer back to 0.
    bus.fetch_req  = 2'b11;
    bus.fetch_addr = {32'h8, 32'h0};
    reset = 1'b0;
    look();
    chk("rst_gnt", bus.fetch_gnt, 2'b00);
    step();
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      look();
      chk("rr_gnt", bus.fetch_gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i > 0) begin
        chk("rr_valid", bus.fetch_valid, (i % 2 == 1) ? 2'b01 : 2'b10);
        if (i % 2 == 1)
          chk("rr_instr0", bus.fetch_instr[31:0], 32'h20080005);
        else
          chk("rr_instr1", bus.fetch_instr[63:32], 32'h11111111);
      end
      step();
    end
    bus.fetch_req = 2'b00;
    look();
    chk("rr_last", bus.fetch_valid, 2'b10);
    step();

    // Misaligned and out-of-range fetches fault with a NOP.
    bus.fetch_req  = 2'b10;
    bus.fetch_addr = {32'h102, 32'h0};
    look();
    chk("flt_gnt", bus.fetch_gnt, 2'b10);
    step();
    bus.fetch_addr = {32'h100, 32'h0};
    look();
    chk("flt_a_fault", bus.fetch_fault, 2'b10);
    chk("flt_a_instr", bus.fetch_instr[63:32], 32'h0);
    step();
    bus.fetch_addr = {32'h8, 32'h0};
    look();
    chk("flt_b_fault", bus.fetch_fault, 2'b10);
    chk("flt_b_instr", bus.fetch_instr[63:32], 32'h0);
    step();
    bus.fetch_req = 2'b00;
    look();
    chk("flt_c_fault", bus.fetch_fault, 2'b00);
    chk("flt_c_instr", bus.fetch_instr[63:32], 32'h11111111);
    step();

    // Load pre-empts both requesters; pointer stays on port 0.
    bus.fetch_req  = 2'b11;
    bus.fetch_addr = {32'h8, 32'hC};
    load_en   = 1'b1;
    load_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      load_data = (i == 0) ? 32'hA5A5A5A5 :
                  (i == 1) ? 32'h5A5A5A5A : 32'hDEADBEEF;
      look();
      chk("ld_gnt", bus.fetch_gnt, 2'b00);
      step();
    end
    load_en = 1'b0;
    look();
    chk("ld_first", bus.fetch_gnt, 2'b01);
    step();
    bus.fetch_req = 2'b10;
    look();
    chk("ld_instr0", bus.fetch_instr[31:0], 32'hDEADBEEF);
    chk("ld_next", bus.fetch_gnt, 2'b10);
    step();
    bus.fetch_req = 2'b00;
    step();

    // Reset right after a grant kills the response; memory survives.
    bus.fetch_req  = 2'b01;
    bus.fetch_addr = {32'h0, 32'h4};
    look();
    chk("r36_gnt", bus.fetch_gnt, 2'b01);
    step();
    reset         = 1'b0;
    bus.fetch_req = 2'b00;
    load_en       = 1'b1;
    load_addr     = 32'h0;
    load_data     = 32'h55555555;
    look();
    chk("r36_valid", bus.fetch_valid, 2'b00);
    chk("r36_instr", bus.fetch_instr, 64'h0);
    chk("r36_fault", bus.fetch_fault, 2'b00);
    step();
    load_en = 1'b0;
    reset   = 1'b1;
    bus.fetch_req  = 2'b01;
    bus.fetch_addr = {32'h0, 32'h0};
    look();
    chk("r36_gnt2", bus.fetch_gnt, 2'b01);
    step();
    bus.fetch_req = 2'b00;
    look();
    chk("r36_valid2", bus.fetch_valid, 2'b01);
    chk("r36_keep", bus.fetch_instr[31:0], 32'h20080005);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_arb.md
INSTR_MEM_ARB -- requirements
Module: instr_mem_arb

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of independent fetch ports, one per core.
REQ-002 Parameter DEPTH, default 64: instruction words stored.
REQ-003 Parameter DATA_W, default 32: instruction word width.
REQ-004 Parameter ADDR_W, default 32: byte-address width of fetch and load ports.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 fetch_req  input  NUM_PORTS  per-port fetch request, level, held until granted.
REQ-008 fetch_addr  input  NUM_PORTS*ADDR_W  per-port byte address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 fetch_gnt  output  NUM_PORTS  combinational one-hot grant for the current cycle.
REQ-010 fetch_valid  output  NUM_PORTS  registered one-cycle response strobe.
REQ-011 fetch_instr  output  NUM_PORTS*DATA_W  registered per-port instruction word.
REQ-012 fetch_fault  output  NUM_PORTS  registered per-port fault flag, qualified by fetch_valid.
REQ-013 load_en  input  1  program-load write enable.
REQ-014 load_addr  input  ADDR_W  program-load byte address.
REQ-015 load_data  input  DATA_W  program-load write data.

Function
REQ-016 Word index SHALL be address >> 2; memory is a single-read-port array of DEPTH x DATA_W, zero-filled at time 0.
REQ-017 Exactly one fetch SHALL be granted per cycle at most; fetch_gnt SHALL be one-hot or all-zero.
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr, wraps from NUM_PORTS-1 to 0; first asserted fetch_req wins.
REQ-019 On a grant to port g, rr_ptr SHALL update to (g+1) mod NUM_PORTS at the clock edge; with no grant, rr_ptr holds.
REQ-020 fetch_gnt[p] SHALL only be asserted while fetch_req[p]=1; requester keeps fetch_req and fetch_addr stable until its grant.
REQ-021 When load_en=1, fetch_gnt SHALL be all-zero that cycle (load has priority); rr_ptr holds.
REQ-022 Load: load_en=1 with load_addr[1:0]=0 and index<DEPTH SHALL write load_data at the edge; otherwise write SHALL be ignored, no other effect.
REQ-023 Latency: a grant in cycle N SHALL produce fetch_valid[g]=1 for exactly cycle N+1, fetch_instr[g]=mem[index] as of cycle N.
REQ-024 Fault: granted address with addr[1:0]!=0 or index>=DEPTH SHALL respond on schedule with fetch_fault[g]=1 and fetch_instr[g]=0 (NOP); no array read.
REQ-025 Non-faulting response SHALL drive fetch_fault[g]=0.
REQ-026 fetch_instr[p] and fetch_fault[p] SHALL hold their last response value until port p's next response.
REQ-027 Single-request fast path: a port requesting alone every cycle SHALL be granted every cycle (throughput 1 word/cycle).
REQ-028 A load to an address in cycle N SHALL be visible to a fetch granted in cycle N+1 or later.

Reset
REQ-029 reset=0 SHALL asynchronously clear fetch_valid, fetch_fault, all fetch_instr to 0 and rr_ptr to 0.
REQ-030 Memory contents SHALL be retained through reset; load writes SHALL be suppressed while reset=0.
REQ-031 A grant issued in the cycle reset asserts SHALL produce no response; fetch_gnt SHALL be all-zero while reset=0.

Verification
REQ-032 Load words 0x20080005 at 0x0 and 0x2009000A at 0x4, port0 fetches 0x4 -> gnt[0] same cycle, next cycle valid[0]=1, instr0=0x2009000A, fault0=0.
REQ-033 Both ports request continuously from reset -> grants alternate 0,1,0,1; each valid pulse one cycle after its grant with correct word.
REQ-034 Port1 fetches 0x102 then 0x100 (DEPTH=64) -> both responses fault1=1, instr1=0; subsequent fetch of 0x8 fault1=0.
REQ-035 load_en=1 with both ports requesting for 3 cycles -> no grants, rr_ptr unchanged; first grant after load_en falls goes to rr_ptr port and returns newly loaded data.
REQ-036 Assert reset=0 in the cycle after a grant -> valid, instr, fault cleared immediately, no stale pulse; after release, fetch of 0x0 returns pre-reset loaded word.
